// File: rtl/count_ctrl_pkg.sv
// Shared state encoding for the run/pause/clear/load counter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package count_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_ctrl_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles.
// Latency: tick is combinational from the prescaler register (high while it equals PRESCALE-1).
// Backpressure: none; disabling or clearing restarts the full interval.
module tick_gen #(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next prescaler value: held at zero unless enabled, wraps after the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear/load controller around a modulo-(TERM+1) event counter.
// Latency: a pulse sampled at edge N is visible on count/state right after edge N.
// Backpressure: none; only the highest-priority pulse in a cycle acts, the rest are dropped.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 100000,
  parameter int TERM     = 9999,
  parameter int WRAP     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_stop_p,
  input  logic               clear_p,
  input  logic               load_p,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  output logic [WIDTH-1:0]   count,
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic               tc_pulse
);

  localparam logic [WIDTH-1:0] TERM_W = WIDTH'(TERM);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic [WIDTH-1:0] load_clamped;

  // The prescaler only runs in RUN; a load restarts the tick interval.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == ST_RUN),
    .clr     (load_p),
    .tick    (tick)
  );

  assign load_clamped = (load_val > TERM_W) ? TERM_W : load_val;

  // Next-state/count logic in priority order clear > load > start_stop > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear_p) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load_p) begin
      count_d = load_clamped;
      // Loading out of DONE re-arms the controller; other states keep their mode.
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else if (start_stop_p) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (tick) begin
      if (!dir) begin
        if (count_q == TERM_W) begin
          tc_d = 1'b1;
          if (WRAP != 0) begin
            count_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (WRAP != 0) begin
            count_d = TERM_W;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State, count and terminal-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign running  = (state_q == ST_RUN);
  assign tc_pulse = tc_q;

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Run/pause/clear/load controller wrapped around a WIDTH-bit event counter; the counter advances on a prescaled tick, not every clock.
Accepts single-cycle, already-debounced button pulses and sequences the counter through idle, run, pause and done.
Drives the count value to the 7-segment display driver, plus status flags for LEDs.
Sits between the debouncers and the display driver.

Parameters:
WIDTH, 16, width of count, load_val and TERM.
PRESCALE, 100000, clocks per count tick while running; legal range >= 1; 1 means a tick every RUN cycle.
TERM, 9999, terminal value; must be < 2**WIDTH; count range is 0..TERM.
WRAP, 1, 1 = wrap at terminal and keep running; 0 = stop at terminal and enter DONE.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset_n  in  1  reset, synchronous and active-low.
start_stop_p  in  1  debounced one-cycle pulse; toggles run/pause.
clear_p  in  1  debounced one-cycle pulse; count <= 0 and state <= IDLE.
load_p  in  1  one-cycle pulse; count <= load_val, clamped to TERM.
load_val  in  WIDTH  preset value; sampled only in the cycle load_p is high.
dir  in  1  0 = count up, 1 = count down; sampled on each tick.
count  out  WIDTH  current count, registered.
state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
running  out  1  high iff state == RUN; decoded from the state register.
tc_pulse  out  1  registered one-cycle pulse when a terminal boundary is crossed.

Behaviour:
- Reset (reset_n low at a clk edge):
  - count=0, state=IDLE, tc_pulse=0, prescaler=0.
  - Reset overrides all other inputs in that cycle.
- Per-cycle priority: reset > clear_p > load_p > start_stop_p > tick.
  - Only the highest-priority event acts in a given cycle; lower ones are dropped.
- Latency: an input pulse sampled at edge N is reflected in count/state after edge N; no extra pipeline stage.
- Prescaler:
  - Counts 0..PRESCALE-1 only while state==RUN.
  - tick is high in the cycle the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - Forced to 0 whenever state != RUN and on every load_p.
  - First tick therefore occurs PRESCALE cycles after entering RUN, and a PAUSE/RUN cycle restarts the full interval.
- FSM transitions:
  - IDLE: start_stop_p -> RUN; load_p -> IDLE with the new count.
  - RUN: start_stop_p -> PAUSE.
    - On a tick with WRAP=0 at the terminal boundary -> DONE.
    - load_p loads count, stays in RUN, and clears the prescaler.
  - PAUSE: start_stop_p -> RUN; load_p loads count and stays in PAUSE.
  - DONE: start_stop_p is ignored; load_p -> IDLE with the loaded count; clear_p -> IDLE.
  - Any state: clear_p -> IDLE with count=0.
- Counting on tick (RUN only):
  - Up, count < TERM: count+1.
  - Up, count == TERM:
    - WRAP=1: count <= 0, tc_pulse=1.
    - WRAP=0: count holds at TERM, tc_pulse=1, state <= DONE.
  - Down, count > 0: count-1.
  - Down, count == 0:
    - WRAP=1: count <= TERM, tc_pulse=1.
    - WRAP=0: count holds at 0, tc_pulse=1, state <= DONE.
- Counter arithmetic is modulo TERM+1, never modulo 2**WIDTH. count must never exceed TERM.
- load_val > TERM loads TERM.
- A dir change between ticks takes effect at the next tick only.
- tc_pulse is high for exactly the one cycle following the boundary tick; otherwise 0.
- clear_p or load_p coincident with a boundary tick:
  - clear/load wins; no tc_pulse is generated.
  - The state follows the clear/load rule.

Decomposition:
- Package count_ctrl_pkg holds the state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE and the 2-bit state width.
- One sub-module, tick_gen:
  - Parameters PRESCALE; ports clk, reset_n, en, clr, tick.
  - Width is ceil(log2(PRESCALE)) with a minimum of 1.
- The FSM and count register stay in count_ctrl.

Test Plan (WIDTH=16, PRESCALE=4, TERM=9 unless noted):
1. Reset with load_val=5 and load_p pulsed during reset -> count=0, state=IDLE, tc_pulse=0. Release, wait 20 cycles -> count still 0.
2. start_stop_p at cycle 0 with dir=0 -> state=RUN after edge 0; count=1 after 4 clocks, 2 after 8. start_stop_p again -> state=PAUSE; count frozen for 20 cycles.
3. WRAP=1, load_val=8, load_p, then start -> count 8 -> 9 -> 0 over two ticks. tc_pulse high exactly one cycle with count=0; state remains RUN.
4. WRAP=0, dir=1, load 1, start -> after 2 ticks count=0, tc_pulse one cycle, state=DONE. start_stop_p ignored; clear_p -> IDLE with count=0.
5. load_val=50000 -> count=9.
6. Simultaneous start_stop_p+clear_p in RUN -> IDLE, count=0.
7. Simultaneous load_p+tick at count=9 -> count=load_val, no tc_pulse.
8. reset_n low mid-RUN at count=6 -> next edge count=0, state=IDLE, prescaler restarted.
